window_generator: RTL and testbench

- Upstream neighbour of the per-pixel filter operation stage.
- Converts a raster pixel stream into an Ope_Size x Ope_Size neighbourhood on the packed 9-bit-per-tap data_bus that the operation stage consumes.
- Holds Ope_Size-1 line buffers and a window register array.
- Flags a window valid only when it lies fully inside the image.

---
 rtl/pixel_pkg.sv | 26 ++
 rtl/line_buffer.sv | 64 ++++++
 rtl/window_generator.sv | 170 +++++++++++++++++
 tb/tb_window_generator.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the window generator and its line buffers.
//   PIX_W     : width of one pixel value
//   TAP_W     : width of one packed window tap ({valid, pixel})
//   VALID_BIT : position of the valid flag inside a tap
//   state_e   : window generator fill/run state encoding
//   tap_offset: bit offset of tap (y,x) inside the packed window bus
// -----------------------------------------------------------------------------
package pixel_pkg;

  localparam int PIX_W     = 8;
  localparam int TAP_W     = 9;
  localparam int VALID_BIT = 8;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Row-major packing: y=0 is the oldest (top) row, x=0 the leftmost column.
  function automatic int tap_offset(input int ope_size, input int y, input int x);
    return (y * ope_size + x) * TAP_W;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// Delay line of DEPTH accepted samples, built as a circular buffer over an
// inferred RAM with a registered read port. dout_o always presents the sample
// written DEPTH shifts ago; it is valid to consume in the same cycle shift_i
// is asserted (read-before-write behaviour).
// Ports:
//   clk    : system clock
//   rst    : synchronous active-low reset (pointer only; contents kept)
//   shift_i: advance the line by one sample, writing din_i
//   din_i  : incoming sample
//   dout_o : sample that entered DEPTH shifts ago
// -----------------------------------------------------------------------------
module line_buffer
  import pixel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_q;

  always_comb begin
    ptr_d = ptr_q;
    if (shift_i) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  // Pre-fetch the slot the pointer will sit on next cycle. On a shift that is
  // ptr_q+1, which differs from the slot being written, so the read never
  // collides with the write (DEPTH >= 2).
  assign rd_addr = (!rst) ? '0 : ptr_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_i) begin
      mem_q[ptr_q] <= din_i;
    end
    rd_q <= mem_q[rd_addr];
  end

  assign dout_o = rd_q;

endmodule

// File: rtl/window_generator.sv
// -----------------------------------------------------------------------------
// window_generator
// Turns a raster pixel stream into an Ope_Size x Ope_Size neighbourhood for the
// per-pixel operation stage. A window is flagged valid only when it lies fully
// inside the current frame.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-low reset
//   reflesh   : synchronous frame restart (active-high), same effect as reset
//   pixel_in  : [8]=pixel valid, [7:0]=pixel value, raster order
//   data_bus  : packed taps, tap (y,x) at ((y*Ope_Size+x)*9)+:9, [8]=valid
//   frame_end : one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module window_generator
  import pixel_pkg::*;
#(
  parameter int Ope_Size   = 3,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 reflesh,
  input  logic [TAP_W-1:0]                     pixel_in,
  output logic [TAP_W*Ope_Size*Ope_Size-1:0]   data_bus,
  output logic                                 frame_end
);

  localparam int N  = Ope_Size;
  localparam int NL = Ope_Size - 1;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic             clear;
  logic             accept;
  logic [PIX_W-1:0] pix;

  logic [PIX_W-1:0] lb_in  [NL];
  logic [PIX_W-1:0] lb_out [NL];
  logic [PIX_W-1:0] col_in [N];

  logic [PIX_W-1:0] win_q  [N][N];
  logic [PIX_W-1:0] win_d  [N][N];

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             frame_end_q, frame_end_d;
  logic             last_col, last_row;

  // Reset wins over reflesh, but both clear the same state.
  assign clear  = !rst || reflesh;
  assign accept = pixel_in[VALID_BIT] && !clear;
  assign pix    = pixel_in[PIX_W-1:0];

  // Line buffers: line 0 takes the live pixel, line k feeds line k+1, so the
  // output of line k is the pixel k+1 rows above the current one.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_lines
      if (gi == 0) begin : g_first
        assign lb_in[gi] = pix;
      end else begin : g_chain
        assign lb_in[gi] = lb_out[gi-1];
      end

      line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
      ) u_line (
        .clk     (clk),
        .rst     (rst),
        .shift_i (accept),
        .din_i   (lb_in[gi]),
        .dout_o  (lb_out[gi])
      );
    end

    // New right column, oldest row first: row y takes line N-2-y, bottom row
    // takes the live pixel.
    for (gi = 0; gi < N; gi++) begin : g_col_in
      if (gi == N - 1) begin : g_live
        assign col_in[gi] = pix;
      end else begin : g_buf
        assign col_in[gi] = lb_out[N-2-gi];
      end
    end

    // Window shifts left by one column on each accept.
    for (gi = 0; gi < N; gi++) begin : g_win_row
      for (gj = 0; gj < N; gj++) begin : g_win_col
        if (gj == N - 1) begin : g_right
          assign win_d[gi][gj] = accept ? col_in[gi] : win_q[gi][gj];
        end else begin : g_shift
          assign win_d[gi][gj] = accept ? win_q[gi][gj+1] : win_q[gi][gj];
        end

        always_ff @(posedge clk) begin
          if (clear) begin
            win_q[gi][gj] <= '0;
          end else begin
            win_q[gi][gj] <= win_d[gi][gj];
          end
        end

        assign data_bus[tap_offset(N, gi, gj) +: TAP_W] = {valid_q, win_q[gi][gj]};
      end
    end
  endgenerate

  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

  // Counters, FSM and output flags.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    state_d     = state_q;
    valid_d     = 1'b0;
    frame_end_d = 1'b0;

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      frame_end_d = last_col && last_row;
    end

    case (state_q)
      S_FILL: begin
        // Entering row Ope_Size-1 means the line buffers hold a full
        // neighbourhood of this frame.
        if (accept && last_col && (row_q == RW'(N - 2))) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Windows straddling the line wrap are never valid.
        valid_d = accept && (col_q >= CW'(N - 1));
        if (frame_end_d) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      col_q       <= '0;
      row_q       <= '0;
      state_q     <= S_FILL;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_window_generator.sv
// -----------------------------------------------------------------------------
// tb_window_generator
// Scoreboard bench for window_generator on an 8x6 image with 3x3 windows.
// A reference model builds each expected window from a 2-D copy of the frame
// and queues it; a negedge monitor pops and compares whenever the DUT flags a
// valid window. Directed first-window taps are also checked against
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_window_generator;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int BW = 9 * N * N;
  localparam int WIN_PER_FRAME = (W - N + 1) * (H - N + 1);
  localparam int FRAMES_EXPECTED = 6;

  logic          clk;
  logic          rst;
  logic          reflesh;
  logic [8:0]    pixel_in;
  logic [BW-1:0] data_bus;
  logic          frame_end;

  window_generator #(
    .Ope_Size   (N),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reflesh   (reflesh),
    .pixel_in  (pixel_in),
    .data_bus  (data_bus),
    .frame_end (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]    img [H][W];
  logic [BW-1:0] sb_q [$];
  int            m_row = 0;
  int            m_col = 0;
  bit            started   = 0;
  bit            exp_zero  = 1;
  bit            exp_valid = 0;
  bit            exp_stall = 0;
  bit            exp_fe    = 0;

  // Monitor state
  int            win_cnt  = 0;
  int            fe_count = 0;
  logic [BW-1:0] prev_fields = '0;

  function automatic logic [BW-1:0] build_window(input int r, input int c,
                                                 input logic [7:0] p);
    logic [BW-1:0] w;
    logic [7:0]    v;
    w = '0;
    for (int y = 0; y < N; y++) begin
      for (int x = 0; x < N; x++) begin
        if (y == N - 1 && x == N - 1) v = p;
        else v = img[r - (N - 1) + y][c - (N - 1) + x];
        w[(y * N + x) * 9 +: 9] = {1'b1, v};
      end
    end
    return w;
  endfunction

  function automatic logic [BW-1:0] pixel_fields(input logic [BW-1:0] b);
    logic [BW-1:0] f;
    f = b;
    for (int t = 0; t < N * N; t++) f[t * 9 + 8] = 1'b0;
    return f;
  endfunction

  // Reference model: evaluates the input consumed at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      started = 1;
      if (!rst || reflesh) begin
        m_row = 0; m_col = 0;
        exp_zero = 1; exp_valid = 0; exp_stall = 0; exp_fe = 0;
      end else begin
        exp_zero = 0;
        if (pixel_in[8]) begin
          exp_stall = 0;
          if (m_row >= N - 1 && m_col >= N - 1) begin
            exp_valid = 1;
            sb_q.push_back(build_window(m_row, m_col, pixel_in[7:0]));
          end else begin
            exp_valid = 0;
          end
          img[m_row][m_col] = pixel_in[7:0];
          exp_fe = (m_row == H - 1) && (m_col == W - 1);
          if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
          end else begin
            m_col = m_col + 1;
          end
        end else begin
          exp_valid = 0;
          exp_stall = 1;
          exp_fe    = 0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs half a cycle after each rising edge.
  initial begin
    logic [BW-1:0] exp_w;
    logic          v0;
    bit            mixed;
    forever begin
      @(negedge clk);
      if (started) begin
        v0 = data_bus[8];
        mixed = 0;
        for (int t = 1; t < N * N; t++) if (data_bus[t * 9 + 8] !== v0) mixed = 1;

        checks++;
        if (mixed) begin
          errors++;
          $display("FAIL valid_uniform: got %h, required all tap valid bits equal", data_bus);
        end

        checks++;
        if (frame_end !== exp_fe) begin
          errors++;
          $display("FAIL frame_end: got %b, required %b", frame_end, exp_fe);
        end

        checks++;
        if (v0 !== exp_valid) begin
          errors++;
          $display("FAIL window_valid: got %b, required %b (bus %h)", v0, exp_valid, data_bus);
        end

        if (exp_zero) begin
          checks++;
          if (data_bus !== '0) begin
            errors++;
            $display("FAIL reset_bus: got %h, required 0", data_bus);
          end
          win_cnt = 0;
        end

        if (exp_valid) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got window %h, required a queued expectation", data_bus);
          end else begin
            exp_w = sb_q.pop_front();
            if (v0 === 1'b1) begin
              win_cnt++;
              if (data_bus !== exp_w) begin
                errors++;
                $display("FAIL window_data: got %h, required %h", data_bus, exp_w);
              end
            end
          end
        end

        if (exp_stall) begin
          checks++;
          if (pixel_fields(data_bus) !== prev_fields) begin
            errors++;
            $display("FAIL stall_hold: got %h, required %h", pixel_fields(data_bus), prev_fields);
          end
        end

        if (frame_end === 1'b1) begin
          fe_count++;
          checks++;
          if (win_cnt != WIN_PER_FRAME) begin
            errors++;
            $display("FAIL windows_per_frame: got %0d, required %0d", win_cnt, WIN_PER_FRAME);
          end
          $display("frame_end: %0d valid windows", win_cnt);
          win_cnt = 0;
        end

        prev_fields = pixel_fields(data_bus);
      end
    end
  end

  // Drive one input word; it is consumed at the next rising edge.
  task automatic send(input logic [8:0] v);
    pixel_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_tap(input int y, input int x, input logic [7:0] exp, input string name);
    logic [8:0] tap;
    tap = data_bus[(y * N + x) * 9 +: 9];
    checks++;
    if (tap !== {1'b1, exp}) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, tap, {1'b1, exp});
    end else begin
      $display("tap(%0d,%0d) %s = %h", y, x, name, tap[7:0]);
    end
  endtask

  // One frame of pixel = base + row*16 + col. Optionally a stall after every
  // pixel, a hand check of the first valid window, and an early abort.
  task automatic send_frame(input int base, input bit stall, input bit hand,
                            input int abort_r, input int abort_c);
    logic [7:0] b;
    b = 8'(base);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send({1'b1, 8'(base + r * 16 + c)});
        if (hand && r == N - 1 && c == N - 1) begin
          @(negedge clk);
          check_tap(0, 0, b,          "first_top_left");
          check_tap(1, 1, b + 8'h11,  "first_centre");
          check_tap(2, 2, b + 8'h22,  "first_bottom_right");
        end
        if (stall) send({1'b0, 8'hEE});
        if (r == abort_r && c == abort_c) return;
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    reflesh  = 1'b0;
    pixel_in = '0;

    // 1: reset held with valid pixels on the input
    for (int i = 0; i < 3; i++) send({1'b1, 8'(8'h30 + i)});
    rst = 1'b1;

    // 2: plain ramp
    send_frame(0, 1'b0, 1'b1, -1, -1);
    send({1'b0, 8'h00});
    send({1'b0, 8'h00});

    // 3: same ramp, stall after every pixel
    send_frame(0, 1'b1, 1'b1, -1, -1);
    send({1'b0, 8'h00});

    // 4: reflesh mid-frame after (3,4)
    send_frame(0, 1'b0, 1'b0, 3, 4);
    reflesh = 1'b1;
    send({1'b1, 8'h77});
    reflesh = 1'b0;
    send_frame(8'h40, 1'b0, 1'b1, -1, -1);
    send({1'b0, 8'h00});

    // 5: back-to-back frames
    send_frame(0, 1'b0, 1'b0, -1, -1);
    send_frame(8'h80, 1'b0, 1'b1, -1, -1);
    send({1'b0, 8'h00});

    // 6: reset together with reflesh mid-row in S_RUN, then recovery
    send_frame(0, 1'b0, 1'b0, 3, 4);
    rst = 1'b0;
    reflesh = 1'b1;
    send({1'b1, 8'h66});
    rst = 1'b1;
    reflesh = 1'b0;
    send_frame(8'h40, 1'b0, 1'b1, -1, -1);

    for (int i = 0; i < 4; i++) send({1'b0, 8'h00});

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending windows, required 0", sb_q.size());
    end
    checks++;
    if (fe_count != FRAMES_EXPECTED) begin
      errors++;
      $display("FAIL frame_end_count: got %0d, required %0d", fe_count, FRAMES_EXPECTED);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
